// File: rtl/lia_pkg.sv
// rtl/lia_pkg.sv - shared state encoding and default widths for the lock-in sweep controller
package lia_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_MIXER_WIDTH = 24;
    localparam int DEF_CNT_WIDTH   = 16;
    localparam int DEF_ACC_WIDTH   = DEF_MIXER_WIDTH + DEF_CNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_INTEGRATE = 2'd2,
        ST_RESULT    = 2'd3
    } lia_state_e;

endpackage

// File: rtl/lia_iq_accumulator.sv
// rtl/lia_iq_accumulator.sv - dual-channel I/Q integrate-and-dump with clear, enable and sample count
module lia_iq_accumulator
    import lia_pkg::*;
#(
    parameter int MIXER_WIDTH = DEF_MIXER_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [MIXER_WIDTH-1:0] i_i,
    input  logic signed [MIXER_WIDTH-1:0] q_i,
    output logic signed [ACC_WIDTH-1:0] sum_i_o,
    output logic signed [ACC_WIDTH-1:0] sum_q_o,
    output logic        [CNT_WIDTH-1:0] count_o
);

    logic signed [ACC_WIDTH-1:0] acc_i_q;
    logic signed [ACC_WIDTH-1:0] acc_q_q;
    logic        [CNT_WIDTH-1:0] count_q;
    logic signed [ACC_WIDTH-1:0] ext_i;
    logic signed [ACC_WIDTH-1:0] ext_q;

    assign ext_i = {{(ACC_WIDTH-MIXER_WIDTH){i_i[MIXER_WIDTH-1]}}, i_i};
    assign ext_q = {{(ACC_WIDTH-MIXER_WIDTH){q_i[MIXER_WIDTH-1]}}, q_i};

    // Sums include the presented sample so the caller can capture the final total in the same cycle.
    assign sum_i_o = acc_i_q + ext_i;
    assign sum_q_o = acc_q_q + ext_q;
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            count_q <= '0;
        end else if (en_i) begin
            acc_i_q <= sum_i_o;
            acc_q_q <= sum_q_o;
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/lia_sweep_controller.sv
// rtl/lia_sweep_controller.sv - frequency-sweep sequencer: step NCO, settle, integrate I/Q, hand off result
module lia_sweep_controller
    import lia_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int MIXER_WIDTH = DEF_MIXER_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic        [PHASE_WIDTH-1:0] f_start,
    input  logic        [PHASE_WIDTH-1:0] f_step,
    input  logic        [CNT_WIDTH-1:0]   n_points,
    input  logic        [CNT_WIDTH-1:0]   settle_cycles,
    input  logic        [CNT_WIDTH-1:0]   integ_samples,
    output logic        [PHASE_WIDTH-1:0] phase_increment,
    input  logic signed [MIXER_WIDTH-1:0] mixer_i_in,
    input  logic signed [MIXER_WIDTH-1:0] mixer_q_in,
    input  logic                          mixer_valid,
    output logic signed [ACC_WIDTH-1:0]   result_i,
    output logic signed [ACC_WIDTH-1:0]   result_q,
    output logic        [CNT_WIDTH-1:0]   result_idx,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          busy,
    output logic                          done
);

    lia_state_e state_q, state_d;

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] step_q, step_d;
    logic [CNT_WIDTH-1:0]   npts_q, npts_d;
    logic [CNT_WIDTH-1:0]   settle_q, settle_d;
    logic [CNT_WIDTH-1:0]   integ_q, integ_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   settle_cnt_q, settle_cnt_d;

    logic signed [ACC_WIDTH-1:0] res_i_q, res_i_d;
    logic signed [ACC_WIDTH-1:0] res_q_q, res_q_d;
    logic        [CNT_WIDTH-1:0] res_idx_q, res_idx_d;
    logic                        res_valid_q, res_valid_d;
    logic                        done_q, done_d;

    logic                        acc_clr;
    logic                        acc_en;
    logic signed [ACC_WIDTH-1:0] sum_i;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic        [CNT_WIDTH-1:0] acc_count;

    lia_iq_accumulator #(
        .MIXER_WIDTH (MIXER_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .i_i     (mixer_i_in),
        .q_i     (mixer_q_in),
        .sum_i_o (sum_i),
        .sum_q_o (sum_q),
        .count_o (acc_count)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        npts_d       = npts_q;
        settle_d     = settle_q;
        integ_d      = integ_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        res_i_d      = res_i_q;
        res_q_d      = res_q_q;
        res_idx_d    = res_idx_q;
        res_valid_d  = res_valid_q;
        done_d       = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && (n_points != '0) && (integ_samples != '0)) begin
                    phase_d      = f_start;
                    step_d       = f_step;
                    npts_d       = n_points;
                    settle_d     = settle_cycles;
                    integ_d      = integ_samples;
                    idx_d        = '0;
                    settle_cnt_d = settle_cycles;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    acc_clr = 1'b1;
                    state_d = ST_INTEGRATE;
                end else begin
                    settle_cnt_d = settle_cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_INTEGRATE: begin
                if (mixer_valid) begin
                    acc_en = 1'b1;
                    // integ_q is nonzero here, so integ_q-1 never underflows.
                    if (acc_count == integ_q - CNT_WIDTH'(1)) begin
                        res_i_d     = sum_i;
                        res_q_d     = sum_q;
                        res_idx_d   = idx_q;
                        res_valid_d = 1'b1;
                        state_d     = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == npts_q - CNT_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d        = idx_q + CNT_WIDTH'(1);
                        phase_d      = phase_q + step_q;
                        settle_cnt_d = settle_q;
                        state_d      = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle start or final handshake.
        if (abort) begin
            state_d     = ST_IDLE;
            phase_d     = phase_q;
            res_valid_d = 1'b0;
            done_d      = 1'b0;
            acc_en      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            step_q       <= '0;
            npts_q       <= '0;
            settle_q     <= '0;
            integ_q      <= '0;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            res_i_q      <= '0;
            res_q_q      <= '0;
            res_idx_q    <= '0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            npts_q       <= npts_d;
            settle_q     <= settle_d;
            integ_q      <= integ_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            res_i_q      <= res_i_d;
            res_q_q      <= res_q_d;
            res_idx_q    <= res_idx_d;
            res_valid_q  <= res_valid_d;
            done_q       <= done_d;
        end
    end

    assign phase_increment = phase_q;
    assign result_i        = res_i_q;
    assign result_q        = res_q_q;
    assign result_idx      = res_idx_q;
    assign result_valid    = res_valid_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_lia_sweep_controller.sv
// tb/tb_lia_sweep_controller.sv - directed scoreboard bench for lia_sweep_controller
module tb_lia_sweep_controller;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, abort;
    logic        [31:0] f_start, f_step;
    logic        [15:0] n_points, settle_cycles, integ_samples;
    logic        [31:0] phase_increment;
    logic signed [23:0] mixer_i_in, mixer_q_in;
    logic               mixer_valid;
    logic signed [39:0] result_i, result_q;
    logic        [15:0] result_idx;
    logic               result_valid, result_ready, busy, done;

    always #5 clk = ~clk;

    lia_sweep_controller dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .f_start         (f_start),
        .f_step          (f_step),
        .n_points        (n_points),
        .settle_cycles   (settle_cycles),
        .integ_samples   (integ_samples),
        .phase_increment (phase_increment),
        .mixer_i_in      (mixer_i_in),
        .mixer_q_in      (mixer_q_in),
        .mixer_valid     (mixer_valid),
        .result_i        (result_i),
        .result_q        (result_q),
        .result_idx      (result_idx),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        logic signed [39:0] si;
        logic signed [39:0] sq;
        logic        [15:0] idx;
        logic        [31:0] ph;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   d0;
    int   wait_n;
    longint big;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_pt(input logic signed [39:0] si, input logic signed [39:0] sq,
                           input logic [15:0] idx, input logic [31:0] ph);
        exp_t e;
        e.si = si; e.sq = sq; e.idx = idx; e.ph = ph;
        sb.push_back(e);
    endtask

    // Observe just before the rising edge, then return 1 time unit after it.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            chk("busy_low_with_done", busy, 0);
        end
        if (result_valid === 1'b1 && result_ready === 1'b1 && abort === 1'b0) begin
            chk("result_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_i", result_i, e.si);
                chk("res_q", result_q, e.sq);
                chk("res_idx", result_idx, e.idx);
                chk("res_phase", phase_increment, e.ph);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] n,
                               input logic [15:0] s, input logic [15:0] ig);
        f_start = fs; f_step = fst; n_points = n; settle_cycles = s; integ_samples = ig;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int max_cyc);
        int d_start;
        int n;
        d_start = done_cnt;
        n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        chk("sweep_timeout", busy, 0);
        step();
        chk("done_count", done_cnt, d_start + 1);
        chk("done_single_pulse", done, 0);
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!result_valid && n < max_cyc) begin
            step();
            n++;
        end
        chk("wait_result_valid", result_valid, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_step = '0; n_points = '0; settle_cycles = '0; integ_samples = '0;
        mixer_i_in = '0; mixer_q_in = '0; mixer_valid = 1'b0; result_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_phase", phase_increment, 0);
        chk("rst_result_i", result_i, 0);
        chk("rst_result_q", result_q, 0);
        chk("rst_result_idx", result_idx, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Basic three-point sweep; config changes after start must be ignored.
        mixer_i_in = 24'sd100; mixer_q_in = -24'sd50; mixer_valid = 1'b1;
        for (int k = 0; k < 3; k++)
            push_pt(40'sd800, -40'sd400, 16'(k), 32'h0100_0000 + 32'(k) * 32'h0010_0000);
        start_sweep(32'h0100_0000, 32'h0010_0000, 16'd3, 16'd4, 16'd8);
        chk("main_first_phase", phase_increment, 32'h0100_0000);
        chk("main_busy", busy, 1);
        f_step = 32'h0000_DEAD; n_points = 16'd1; settle_cycles = 16'd0; integ_samples = 16'd1;
        run_to_idle(300);

        // Settle timing: sample value c+1 in cycle c after the phase update.
        for (int s = 0; s <= 5; s += 5) begin
            push_pt(40'(3 * s + 9), -40'(3 * s + 9), 16'd0, 32'h200);
            start_sweep(32'h200, 32'h1, 16'd1, 16'(s), 16'd3);
            for (int c = 0; c <= s + 3; c++) begin
                mixer_i_in = 24'(c + 1);
                mixer_q_in = -24'(c + 1);
                step();
            end
            mixer_valid = 1'b0;
            run_to_idle(20);
            mixer_valid = 1'b1;
        end

        // Backpressure: outputs hold and no phase step while ready is low.
        result_ready = 1'b0;
        mixer_i_in = 24'sd7; mixer_q_in = 24'sd3;
        push_pt(40'sd28, 40'sd12, 16'd0, 32'h1000);
        push_pt(40'sd28, 40'sd12, 16'd1, 32'h1040);
        start_sweep(32'h1000, 32'h40, 16'd2, 16'd2, 16'd4);
        wait_valid(50);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid", result_valid, 1);
            chk("bp_i", result_i, 40'sd28);
            chk("bp_q", result_q, 40'sd12);
            chk("bp_idx", result_idx, 0);
            chk("bp_phase", phase_increment, 32'h1000);
        end
        result_ready = 1'b1;
        step();
        chk("bp_phase_stepped", phase_increment, 32'h1040);
        chk("bp_valid_dropped", result_valid, 0);
        run_to_idle(100);

        // Extremes: full-scale negative samples over the maximum count, and phase wrap.
        mixer_i_in = 24'sh800000; mixer_q_in = 24'sh800000;
        big = -64'sd8388608 * 64'sd65535;
        push_pt(40'(big), 40'(big), 16'd0, 32'h5);
        start_sweep(32'h5, 32'h0, 16'd1, 16'd0, 16'hFFFF);
        run_to_idle(70000);
        push_pt(-40'sd8388608, -40'sd8388608, 16'd0, 32'hFFFF_FFF0);
        push_pt(-40'sd8388608, -40'sd8388608, 16'd1, 32'h0000_0010);
        start_sweep(32'hFFFF_FFF0, 32'h20, 16'd2, 16'd0, 16'd1);
        run_to_idle(50);

        // Abort in INTEGRATE.
        mixer_i_in = 24'sd1; mixer_q_in = 24'sd1;
        d0 = done_cnt;
        start_sweep(32'h7000, 32'h10, 16'd2, 16'd1, 16'd8);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_phase_hold", phase_increment, 32'h7000);
        repeat (3) step();
        chk("abort_no_done", done_cnt, d0);

        // Abort coincident with the final handshake.
        result_ready = 1'b0;
        start_sweep(32'h8000, 32'h0, 16'd1, 16'd0, 16'd2);
        wait_valid(20);
        result_ready = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_hs_valid", result_valid, 0);
        chk("abort_hs_busy", busy, 0);
        repeat (3) step();
        chk("abort_hs_no_done", done_cnt, d0);

        push_pt(40'sd2, 40'sd2, 16'd0, 32'h9000);
        start_sweep(32'h9000, 32'h0, 16'd1, 16'd0, 16'd2);
        run_to_idle(20);

        // Ignored starts.
        d0 = done_cnt;
        start_sweep(32'hA000, 32'h0, 16'd0, 16'd0, 16'd2);
        chk("zero_n_busy", busy, 0);
        chk("zero_n_phase", phase_increment, 32'h9000);
        start_sweep(32'hA000, 32'h0, 16'd1, 16'd0, 16'd0);
        chk("zero_integ_busy", busy, 0);
        chk("zero_integ_phase", phase_increment, 32'h9000);
        step();
        chk("zero_no_done", done_cnt, d0);

        push_pt(40'sd2, 40'sd2, 16'd0, 32'hB000);
        start_sweep(32'hB000, 32'h0, 16'd1, 16'd10, 16'd2);
        repeat (2) step();
        f_start = 32'hC000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_phase", phase_increment, 32'hB000);
        chk("busy_start_busy", busy, 1);
        run_to_idle(50);

        // Asynchronous reset mid-SETTLE.
        start_sweep(32'hD000, 32'h0, 16'd1, 16'd20, 16'd2);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("arst_phase", phase_increment, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result_i", result_i, 0);
        chk("arst_result_idx", result_idx, 0);
        chk("arst_valid", result_valid, 0);
        step();
        rst = 1'b0;
        step();
        chk("arst_idle", busy, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
